// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//
// Contents:
//   usr_mode_t      3-bit operation select type
//   USR_* params    mode encodings
//   usr_is_shift()  true for modes that move data and advance the shift count
//
// Build option: USR_ROTATE_EN -- when defined, ROR/ROL are real operations that
// count as shifts. When undefined, they decode as HOLD.
package usr_pkg;

    typedef logic [2:0] usr_mode_t;

    localparam usr_mode_t USR_HOLD = 3'b000;
    localparam usr_mode_t USR_SHR  = 3'b001;
    localparam usr_mode_t USR_SHL  = 3'b010;
    localparam usr_mode_t USR_LOAD = 3'b011;
    localparam usr_mode_t USR_ROR  = 3'b100;
    localparam usr_mode_t USR_ROL  = 3'b101;

    function automatic logic usr_is_shift(input usr_mode_t mode);
        logic r;
        r = 1'b0;
        case (mode)
            USR_SHR, USR_SHL: r = 1'b1;
`ifdef USR_ROTATE_EN
            USR_ROR, USR_ROL: r = 1'b1;
`endif
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_shift_counter.sv
// Saturating count of shifts since the last load. shift_done is registered
// together with the count, so it is a clean flop output.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   en          clock enable; low freezes the count and shift_done
//   clear       restart the count (parallel load)
//   inc         one shift accepted this cycle
//   shift_done  count has reached WIDTH
module usr_shift_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    input  logic inc,
    output logic shift_done
);
    import usr_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            shift_done <= 1'b0;
        end else if (en) begin
            if (clear) begin
                cnt        <= '0;
                shift_done <= 1'b0;
            end else if (inc && (cnt != CNT_MAX)) begin
                cnt        <= cnt + 1'b1;
                // Reaching the limit on this increment raises the flag.
                shift_done <= (cnt == CNT_MAX - 1'b1);
            end
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register with hold, parallel load, serial
// shift left/right and optional rotates, plus a shift-done flag that marks a
// fully serialised word since the last load.
//
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   en          clock enable (low = hold regardless of mode)
//   mode        operation select, see usr_pkg
//   din         parallel load data
//   sin_r       serial in at MSB on shift right
//   sin_l       serial in at LSB on shift left
//   q, q_bar    register contents and complement
//   sout_r      q[0]; sout_l: q[WIDTH-1]
//   shift_done  WIDTH shifts have occurred since last load/reset
//
// Build option: USR_ROTATE_EN enables ROR/ROL (codes 100/101); otherwise
// those codes hold.
module universal_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             shift_done
);
    import usr_pkg::*;

    usr_mode_t mode_sel;
    logic      cnt_clear;
    logic      cnt_inc;

    assign mode_sel  = usr_mode_t'(mode);
    assign cnt_clear = (mode_sel == USR_LOAD);
    assign cnt_inc   = usr_is_shift(mode_sel);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            case (mode_sel)
                USR_SHR:  q <= {sin_r, q[WIDTH-1:1]};
                USR_SHL:  q <= {q[WIDTH-2:0], sin_l};
                USR_LOAD: q <= din;
`ifdef USR_ROTATE_EN
                USR_ROR:  q <= {q[0], q[WIDTH-1:1]};
                USR_ROL:  q <= {q[WIDTH-2:0], q[WIDTH-1]};
`endif
                default:  q <= q;
            endcase
        end
    end

    usr_shift_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (cnt_clear),
        .inc        (cnt_inc),
        .shift_done (shift_done)
    );

    assign q_bar  = ~q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    localparam int W = 4;
`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;

    logic         clk = 1'b0;
    logic         rst, en, sin_r, sin_l;
    logic [2:0]   mode;
    logic [W-1:0] din;
    logic [W-1:0] q, q_bar;
    logic         sout_r, sout_l, shift_done;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .q_bar(q_bar),
        .sout_r(sout_r), .sout_l(sout_l), .shift_done(shift_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         en;
        logic [2:0]   mode;
        logic [W-1:0] din;
        logic         sr;
        logic         sl;
        logic [W-1:0] eq;
        logic         ed;
    } vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] eq;
        logic         ed;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic e, logic [2:0] m, logic [W-1:0] d,
                                logic sr, logic sl, logic [W-1:0] eq, logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.din = d; v.sr = sr; v.sl = sl;
        v.eq = eq; v.ed = ed;
        return v;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expected result, then compare after the edge.
    task automatic apply(string name, vec_t v);
        exp_t e;
        @(negedge clk);
        rst = v.rst; en = v.en; mode = v.mode; din = v.din;
        sin_r = v.sr; sin_l = v.sl;
        e.name = name; e.eq = v.eq; e.ed = v.ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.name, ".q"},          q,                   e.eq);
        chk({e.name, ".q_bar"},      q_bar,               ~e.eq);
        chk({e.name, ".sout_r"},     {3'b0, sout_r},      {3'b0, e.eq[0]});
        chk({e.name, ".sout_l"},     {3'b0, sout_l},      {3'b0, e.eq[W-1]});
        chk({e.name, ".shift_done"}, {3'b0, shift_done},  {3'b0, e.ed});
    endtask

    initial begin
        logic [W-1:0] m;
        logic         b;
        rst = 1'b0; en = 1'b0; mode = M_HOLD; din = '0; sin_r = 1'b0; sin_l = 1'b0;

        // reset and load, serialise right
        vecs.push_back(mk(1, 1, M_HOLD, 4'b0000, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, M_LOAD, 4'b1011, 0, 0, 4'b1011, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0101, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0010, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0001, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0000, 1));
        // deserialise left, saturation
        vecs.push_back(mk(0, 1, M_LOAD, 4'b0000, 0, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, M_SHL,  4'b0000, 0, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 1, M_SHL,  4'b0000, 0, 0, 4'b0010, 0));
        vecs.push_back(mk(0, 1, M_SHL,  4'b0000, 0, 0, 4'b0100, 0));
        vecs.push_back(mk(0, 1, M_SHL,  4'b0000, 0, 1, 4'b1001, 1));
        vecs.push_back(mk(0, 1, M_SHL,  4'b0000, 0, 1, 4'b0011, 1));
        // enable low and reserved codes; load right after done
        vecs.push_back(mk(0, 1, M_LOAD, 4'b0111, 0, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 0, M_SHR,  4'b0000, 1, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 0, M_SHR,  4'b0000, 1, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 0, M_LOAD, 4'b1010, 1, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 1, 3'b110, 4'b1010, 1, 1, 4'b0111, 0));
        vecs.push_back(mk(0, 1, 3'b111, 4'b1010, 1, 1, 4'b0111, 0));
        // count must still be 0: done only on the 4th shift
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 1, 0, 4'b1011, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 1, 0, 4'b1101, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0110, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0011, 1));
        vecs.push_back(mk(0, 0, M_LOAD, 4'b0000, 0, 1, 4'b0011, 1));
        // rotates
        vecs.push_back(mk(0, 1, M_LOAD, 4'b1110, 0, 0, 4'b1110, 0));
        vecs.push_back(mk(0, 1, M_ROL,  4'b0000, 0, 0, ROT ? 4'b1101 : 4'b1110, 0));
        vecs.push_back(mk(0, 1, M_ROL,  4'b0000, 0, 0, ROT ? 4'b1011 : 4'b1110, 0));
        vecs.push_back(mk(0, 1, M_ROR,  4'b0000, 0, 0, ROT ? 4'b1101 : 4'b1110, 0));
        vecs.push_back(mk(0, 1, M_ROR,  4'b0000, 0, 0, 4'b1110, ROT));
        // reset mid-shift, reset beats en=0
        vecs.push_back(mk(0, 1, M_LOAD, 4'b1111, 0, 0, 4'b1111, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0111, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 0, 0, 4'b0011, 0));
        vecs.push_back(mk(1, 1, M_SHR,  4'b0000, 1, 0, 4'b0000, 0));
        vecs.push_back(mk(0, 1, M_SHR,  4'b0000, 1, 0, 4'b1000, 0));
        vecs.push_back(mk(0, 1, M_LOAD, 4'b0101, 0, 0, 4'b0101, 0));
        vecs.push_back(mk(1, 0, M_LOAD, 4'b1111, 0, 0, 4'b0000, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i]);

        // Back-to-back words: random load, W random SHLs, then immediate reload.
        for (int w = 0; w < 3; w++) begin
            m = W'($urandom_range(0, (1 << W) - 1));
            apply($sformatf("w%0d.load", w), mk(0, 1, M_LOAD, m, 0, 0, m, 0));
            for (int i = 0; i < W; i++) begin
                b = 1'($urandom_range(0, 1));
                m = {m[W-2:0], b};
                apply($sformatf("w%0d.shl%0d", w, i),
                      mk(0, 1, M_SHL, 4'b0000, 0, b, m, (i == W - 1)));
            end
        end
        apply("reload", mk(0, 1, M_LOAD, 4'b1100, 0, 0, 4'b1100, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
